// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-channel stream multiplexer with fixed-select or round-robin grant into a single-entry output register
module stream_mux #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic [SELW-1:0]              select,
    output logic [WIDTH-1:0]             out_data,
    output logic [SELW-1:0]              out_chan,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam logic [SELW:0]   CH_W = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load;
    logic             grant_ok;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_word;
    logic [SELW:0]    scan_idx;

    assign load = !out_valid_q || out_ready;

    // Round-robin scans from the far end back to ptr so the last hit is the first in priority order.
    always_comb begin
        grant_ok = 1'b0;
        grant    = '0;
        scan_idx = '0;
        if (MODE == 1) begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                scan_idx = {1'b0, ptr_q} + (SELW+1)'(k);
                if (scan_idx >= CH_W) begin
                    scan_idx = scan_idx - CH_W;
                end
                if (in_valid[scan_idx[SELW-1:0]]) begin
                    grant_ok = 1'b1;
                    grant    = scan_idx[SELW-1:0];
                end
            end
        end else begin
            if (({1'b0, select} < CH_W) && in_valid[select]) begin
                grant_ok = 1'b1;
                grant    = select;
            end
        end
    end

    always_comb begin
        grant_word = '0;
        in_ready   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant == SELW'(c)) begin
                grant_word  = in_data[c*WIDTH +: WIDTH];
                in_ready[c] = reset_n && load && grant_ok;
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = grant_ok;
            if (grant_ok) begin
                out_data_d = grant_word;
                out_chan_d = grant;
                if (MODE == 1) begin
                    ptr_d = (grant == LAST) ? '0 : grant + SELW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - scoreboard bench for stream_mux in fixed-select (4 and 3 channels) and round-robin configurations
module tb_stream_mux;

    localparam int CHS   [3] = '{4, 3, 4};
    localparam int MODES [3] = '{0, 0, 1};

    logic         clk;
    logic         reset_n;
    logic [127:0] data_r  [3];
    logic [3:0]   valid_r [3];
    logic [1:0]   sel_r   [3];
    logic         ordy_r  [3];

    logic [3:0]   rdy_w    [3];
    logic [31:0]  odata_w  [3];
    logic [1:0]   ochan_w  [3];
    logic         ovalid_w [3];

    logic [3:0]  rdy_a, rdy_c;
    logic [2:0]  rdy_b;
    logic [31:0] odata_a, odata_b, odata_c;
    logic [1:0]  ochan_a, ochan_b, ochan_c;
    logic        ovalid_a, ovalid_b, ovalid_c;

    int          n_checks;
    int          n_fail;
    bit          m_valid [3];
    int          m_ptr   [3];
    logic [33:0] sb      [3][$];

    stream_mux #(.WIDTH(32), .CHANNELS(4), .MODE(0)) u_fix4 (
        .clk(clk), .reset_n(reset_n), .in_data(data_r[0]), .in_valid(valid_r[0]),
        .in_ready(rdy_a), .select(sel_r[0]), .out_data(odata_a), .out_chan(ochan_a),
        .out_valid(ovalid_a), .out_ready(ordy_r[0])
    );

    stream_mux #(.WIDTH(32), .CHANNELS(3), .MODE(0)) u_fix3 (
        .clk(clk), .reset_n(reset_n), .in_data(data_r[1][95:0]), .in_valid(valid_r[1][2:0]),
        .in_ready(rdy_b), .select(sel_r[1]), .out_data(odata_b), .out_chan(ochan_b),
        .out_valid(ovalid_b), .out_ready(ordy_r[1])
    );

    stream_mux #(.WIDTH(32), .CHANNELS(4), .MODE(1)) u_rr4 (
        .clk(clk), .reset_n(reset_n), .in_data(data_r[2]), .in_valid(valid_r[2]),
        .in_ready(rdy_c), .select(sel_r[2]), .out_data(odata_c), .out_chan(ochan_c),
        .out_valid(ovalid_c), .out_ready(ordy_r[2])
    );

    assign rdy_w[0]    = rdy_a;
    assign rdy_w[1]    = {1'b0, rdy_b};
    assign rdy_w[2]    = rdy_c;
    assign odata_w[0]  = odata_a;
    assign odata_w[1]  = odata_b;
    assign odata_w[2]  = odata_c;
    assign ochan_w[0]  = ochan_a;
    assign ochan_w[1]  = ochan_b;
    assign ochan_w[2]  = ochan_c;
    assign ovalid_w[0] = ovalid_a;
    assign ovalid_w[1] = ovalid_b;
    assign ovalid_w[2] = ovalid_c;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic string tg(input int d, input string n);
        return $sformatf("d%0d.%s", d, n);
    endfunction

    task automatic model_grant(input int ch, input int mode, input int sel, input logic [3:0] v,
                               input int ptr, output bit ok, output int g);
        int idx;
        ok = 1'b0;
        g  = 0;
        if (mode == 0) begin
            if (sel < ch && v[sel]) begin
                ok = 1'b1;
                g  = sel;
            end
        end else begin
            for (int k = 0; k < ch; k++) begin
                idx = (ptr + k) % ch;
                if (!ok && v[idx]) begin
                    ok = 1'b1;
                    g  = idx;
                end
            end
        end
    endtask

    task automatic flush_model();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 1'b0;
            m_ptr[d]   = 0;
            sb[d].delete();
        end
    endtask

    task automatic check_reset(input string n);
        for (int d = 0; d < 3; d++) begin
            check(tg(d, {n, ".out_valid"}), ovalid_w[d], 0);
            check(tg(d, {n, ".out_data"}), odata_w[d], 0);
            check(tg(d, {n, ".out_chan"}), ochan_w[d], 0);
            check(tg(d, {n, ".in_ready"}), rdy_w[d], 0);
        end
    endtask

    // Called with inputs already driven; checks, updates the model, then advances to the next falling edge.
    task automatic step();
        bit          ok;
        int          g;
        bit          load;
        logic [3:0]  er;
        logic [33:0] e;
        #1;
        for (int d = 0; d < 3; d++) begin
            model_grant(CHS[d], MODES[d], int'(sel_r[d]), valid_r[d], m_ptr[d], ok, g);
            load = !m_valid[d] || ordy_r[d];
            er   = (load && ok) ? 4'(1 << g) : 4'b0;
            check(tg(d, "in_ready"), rdy_w[d], er);
            check(tg(d, "out_valid"), ovalid_w[d], m_valid[d]);
            if (m_valid[d]) begin
                check(tg(d, "sb_depth"), sb[d].size(), 1);
                if (sb[d].size() > 0) begin
                    e = sb[d][0];
                    check(tg(d, "out_data"), odata_w[d], e[31:0]);
                    check(tg(d, "out_chan"), ochan_w[d], e[33:32]);
                    if (ordy_r[d]) void'(sb[d].pop_front());
                end
            end
            if (load) begin
                if (ok) sb[d].push_back({2'(g), data_r[d][g*32 +: 32]});
                m_valid[d] = ok;
                if (ok && MODES[d] == 1) m_ptr[d] = (g + 1) % CHS[d];
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        clk      = 1'b0;
        reset_n  = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        for (int d = 0; d < 3; d++) begin
            data_r[d]  = '0;
            valid_r[d] = '0;
            sel_r[d]   = '0;
            ordy_r[d]  = 1'b1;
        end
        flush_model();
        valid_r[0] = 4'b0001;
        #3;
        check_reset("rst");
        @(negedge clk);
        valid_r[0] = '0;
        reset_n    = 1'b1;

        // fixed select, channel 2
        sel_r[0]   = 2'd2;
        valid_r[0] = 4'b0100;
        data_r[0]  = {$urandom, 32'hA5A5_0002, $urandom, $urandom};
        step();
        check("basic.out_valid", ovalid_w[0], 1);
        check("basic.out_data", odata_w[0], 32'hA5A5_0002);
        check("basic.out_chan", ochan_w[0], 2);
        valid_r[0] = '0;

        // three channels, out-of-range select never grants
        sel_r[1]   = 2'd3;
        valid_r[1] = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            data_r[1] = rnd128();
            step();
            check("illegal.out_valid", ovalid_w[1], 0);
        end
        valid_r[1] = '0;

        // round-robin fairness from reset
        valid_r[2] = 4'hF;
        for (int i = 0; i < 6; i++) begin
            data_r[2] = rnd128();
            step();
            check($sformatf("fair%0d.out_chan", i), ochan_w[2], i % 4);
        end
        valid_r[2] = '0;

        // stall with toggling select and data
        sel_r[0]   = 2'd1;
        valid_r[0] = 4'b0010;
        data_r[0]  = {$urandom, $urandom, 32'h1234_5678, $urandom};
        step();
        check("stall.load", odata_w[0], 32'h1234_5678);
        ordy_r[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel_r[0]   = 2'($urandom);
            valid_r[0] = 4'($urandom);
            data_r[0]  = rnd128();
            step();
            check("stall.out_data", odata_w[0], 32'h1234_5678);
            check("stall.out_chan", ochan_w[0], 1);
        end
        ordy_r[0]  = 1'b1;
        sel_r[0]   = 2'd3;
        valid_r[0] = 4'b1000;
        data_r[0]  = {32'hCAFE_0003, $urandom, $urandom, $urandom};
        step();
        check("unstall.out_data", odata_w[0], 32'hCAFE_0003);
        check("unstall.out_chan", ochan_w[0], 3);
        valid_r[0] = '0;
        step();

        // round-robin wrap: ptr reaches 3, sole requester 0 wins, ptr moves to 1
        valid_r[2] = 4'b0100;
        data_r[2]  = rnd128();
        step();
        valid_r[2] = 4'b0001;
        data_r[2]  = rnd128();
        step();
        check("wrap.out_chan", ochan_w[2], 0);
        valid_r[2] = 4'hF;
        data_r[2]  = rnd128();
        step();
        check("wrap.next_chan", ochan_w[2], 1);
        valid_r[2] = '0;
        step();

        // reset pulse between edges while a word is held
        sel_r[0]   = 2'd0;
        valid_r[0] = 4'b0001;
        data_r[0]  = {$urandom, $urandom, $urandom, 32'h5EED_0000};
        step();
        ordy_r[0]  = 1'b0;
        valid_r[0] = '0;
        step();
        check("held.out_data", odata_w[0], 32'h5EED_0000);
        ordy_r[0]  = 1'b1;
        sel_r[0]   = 2'd1;
        valid_r[0] = 4'b0010;
        #1 reset_n = 1'b0;
        #1;
        check_reset("midrst");
        flush_model();
        #1 reset_n = 1'b1;
        data_r[0] = {$urandom, $urandom, 32'hBEEF_0001, $urandom};
        step();
        check("postrst.out_valid", ovalid_w[0], 1);
        check("postrst.out_data", odata_w[0], 32'hBEEF_0001);
        check("postrst.out_chan", ochan_w[0], 1);
        valid_r[0] = '0;

        step();
        step();
        for (int d = 0; d < 3; d++) begin
            check(tg(d, "sb_drained"), sb[d].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
